// File: rtl/isqrt_pkg.sv
// Shared types and constants for the iterative isqrt block.
// The state enum and the default radicand/result widths live here.
package isqrt_pkg;

    typedef enum logic {
        IDLE,
        CALC
    } isqrt_state_t;

    localparam int ISQRT_W     = 32;
    localparam int ISQRT_RES_W = ISQRT_W / 2;

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit step: consumes the top two radicand
// bits and produces the next partial remainder and partial root.
module isqrt_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH/2+1:0] rem,
    input  logic [WIDTH/2-1:0] root,
    input  logic [1:0]         bits,
    output logic [WIDTH/2+1:0] rem_nxt,
    output logic [WIDTH/2-1:0] root_nxt
);

    localparam int RW    = WIDTH / 2;
    localparam int REM_W = RW + 2;

    logic [REM_W-1:0] rem_t;
    logic [REM_W-1:0] trial;
    logic             take;

    // Trial subtraction of (root<<2)|1 from the shifted-in remainder.
    always_comb begin
        rem_t    = REM_W'({rem, bits});
        trial    = {root, 2'b01};
        take     = (rem_t >= trial);
        rem_nxt  = take ? (rem_t - trial) : rem_t;
        root_nxt = {root[RW-2:0], take};
    end

endmodule

// File: rtl/isqrt_iter_fsm.sv
// Iterative floor(sqrt(x)), one root bit per clock, WIDTH/2+1 cycle latency.
// Optional ISQRT_DROP_CNT_EN adds a saturating count of requests seen while busy.
module isqrt_iter_fsm
    import isqrt_pkg::*;
#(
    parameter int WIDTH = ISQRT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_vld,
    input  logic [WIDTH-1:0]   x,
    output logic               y_vld,
`ifdef ISQRT_DROP_CNT_EN
    output logic [WIDTH/2-1:0] y,
    output logic [7:0]         drop_cnt
`else
    output logic [WIDTH/2-1:0] y
`endif
);

    localparam int RW    = WIDTH / 2;
    localparam int REM_W = RW + 2;
    localparam int IW    = (RW > 1) ? $clog2(RW) : 1;

    isqrt_state_t     state;
    isqrt_state_t     state_nxt;
    logic             load;
    logic             last;

    logic [REM_W-1:0] rem_q;
    logic [RW-1:0]    root_q;
    logic [WIDTH-1:0] rad_q;
    logic [IW-1:0]    iter_q;

    logic [REM_W-1:0] rem_nxt;
    logic [RW-1:0]    root_nxt;

    isqrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .root     (root_q),
        .bits     (rad_q[WIDTH-1 -: 2]),
        .rem_nxt  (rem_nxt),
        .root_nxt (root_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus load/finish strobes for the datapath.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (x_vld) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (iter_q == '0) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands, iterate, register the result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            root_q <= '0;
            rad_q  <= '0;
            iter_q <= '0;
            y      <= '0;
            y_vld  <= 1'b0;
        end else begin
            y_vld <= last;
            if (load) begin
                rad_q  <= x;
                rem_q  <= '0;
                root_q <= '0;
                iter_q <= IW'(RW - 1);
            end else if (state == CALC) begin
                rem_q  <= rem_nxt;
                root_q <= root_nxt;
                rad_q  <= rad_q << 2;
                iter_q <= iter_q - 1'b1;
            end
            if (last) y <= root_nxt;
        end
    end

`ifdef ISQRT_DROP_CNT_EN
    // Saturating count of requests that arrive while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (state == CALC && x_vld && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/isqrt_iter_fsm.md
Name: isqrt_iter_fsm

Overview:
- Responder end of the isqrt request/response interface: accepts a `WIDTH`-bit radicand on `x_vld`/`x` and returns floor(sqrt(x)) on `y_vld`/`y`.
- Iterative digit-recurrence (restoring) square root, one result bit per clock, controlled by a small FSM.
- Instantiated once per isqrt channel beneath the formula FSMs (e.g. behind `isqrt_1_*` and `isqrt_2_*`).

Parameters:
- WIDTH, 32, radicand width; must be even and >= 4; result width is WIDTH/2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- x_vld  input  1  request strobe; `x` is sampled when high and the block is idle
- x  input  WIDTH  radicand, unsigned
- y_vld  output  1  one-cycle result strobe
- y  output  WIDTH/2  floor(sqrt(x)), unsigned
- drop_cnt  output  8  present only with ISQRT_DROP_CNT_EN

Behaviour:
- Reset values: y_vld=0, y=0, state=IDLE, internal remainder/root/radicand/iteration counter=0, drop_cnt=0.
- States:
  - IDLE: if x_vld, load the radicand register with x, clear remainder and root, set iter=WIDTH/2-1, go to CALC. Otherwise stay in IDLE.
  - CALC: perform one iteration per clock. When the iteration with iter==0 completes, go to IDLE.
- Iteration, all unsigned, remainder is WIDTH/2+2 bits:
  - rem_t = (rem<<2) | radicand[WIDTH-1:WIDTH-2]
  - trial = (root<<2) | 1
  - if rem_t >= trial: rem = rem_t - trial, root = (root<<1)|1
  - else: rem = rem_t, root = root<<1
  - radicand <<= 2; iter -= 1
- Completion: on the edge that finishes the last iteration, register y <= final root and y_vld <= 1.
- y_vld is high for exactly one cycle. y holds its value until the next completion.
- Latency: if x_vld is sampled at cycle 0, y_vld=1 in cycle WIDTH/2+1 (17 for WIDTH=32).
- Back-to-back requests: in the cycle y_vld=1 the state is already IDLE, so a new x_vld in that same cycle is accepted. Throughput is one result per WIDTH/2+1 cycles.
- Busy: x_vld while in CALC is ignored. There is no ready signal, and the in-flight result is unaffected.
- Reset mid-operation: rst overrides everything. The next cycle is IDLE with y_vld=0 and y=0, and the pending result is discarded (no y_vld).
- x_vld and rst in the same cycle: rst wins and the request is lost.
- No X propagation: y is never driven from an unloaded register.

Optional Feature:
- Macro: ISQRT_DROP_CNT_EN.
- Defined:
  - Adds output `drop_cnt[7:0]`, which increments on every cycle with state==CALC and x_vld==1.
  - Saturates at 255 and is cleared only by rst.
- Undefined: the port and counter are absent, and ignored requests are silently dropped.
- All other behaviour is identical in both builds.

Decomposition:
- Package `isqrt_pkg` holds:
  - state enum `isqrt_state_t` {IDLE, CALC}
  - default constant ISQRT_W=32
  - derived ISQRT_RES_W = ISQRT_W/2
- Sub-module `isqrt_step` (combinational, parameterised by WIDTH):
  - inputs: rem, root, top two radicand bits
  - outputs: next rem, next root
  - instantiated once in the FSM datapath.

Test Plan:
- x=0, x_vld one cycle -> y_vld only in cycle 17, y=0. Then x=1 -> y=1. Then x=99 -> y=9.
- x=32'hFFFF_FFFF -> y=16'hFFFF. x=32'hFFFE_0001 -> y=16'hFFFF. x=32'hFFFE_0000 -> y=16'hFFFE.
- x=16, then x=25 issued in the exact cycle y_vld=1 -> y=4 at cycle 17, y=5 at cycle 34; y_vld is never high for two consecutive cycles.
- x=144 at cycle 0, x=10000 pulsed at cycles 3 and 10 -> single y_vld with y=12 at cycle 17. With ISQRT_DROP_CNT_EN, drop_cnt=2.
- x=1_000_000 at cycle 0, rst at cycle 8 -> no y_vld, and y=0 from cycle 9. Then x=49 -> y=7 seventeen cycles after its x_vld.
- Random: 10k uniform x values with gaps of 0-3 idle cycles -> every y equals the reference floor(sqrt(x)), one y_vld per accepted request.
